mult_sequencer: RTL and testbench
=================================

MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 2*WIDTH+4, maximum cycles to wait for mul_done.
REQ-003 SHALL have port clk  input  1  sole clock (divided display-domain clock).
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port load_p  input  1  single-cycle debounced load pulse.
REQ-006 SHALL have ports left_p, right_p  input  1 each  single-cycle display-shift pulses.
REQ-007 SHALL have ports num1, num2  input  WIDTH each  two's-complement operands.
REQ-008 SHALL have ports mul_a, mul_b  output  WIDTH each  unsigned magnitudes to the shift-add multiplier.
REQ-009 SHALL have port mul_start  output  1  single-cycle start strobe to the multiplier.
REQ-010 SHALL have ports mul_done  input  1  and mul_product  input  2*WIDTH  multiplier completion and unsigned product.
REQ-011 SHALL have ports result  output  2*WIDTH  latched magnitude; sign  output  1  result negative.
REQ-012 SHALL have ports busy, result_valid, timeout_err  output  1 each; win_idx  output  2  display window index 0..2.

Function
REQ-013 SHALL implement FSM states IDLE, CAPTURE, START, WAIT, DONE; one transition per clk.
REQ-014 IDLE: load_p=1 -> CAPTURE; otherwise remain.
REQ-015 CAPTURE SHALL register mul_a=|num1|, mul_b=|num2|, pending sign=num1[MSB]^num2[MSB] from the operand values sampled on the load_p cycle; -> START.
REQ-016 Magnitude of the most negative value (-2^(WIDTH-1)) SHALL be 2^(WIDTH-1) carried unsigned in WIDTH bits with no saturation.
REQ-017 START SHALL assert mul_start for exactly one cycle, clear the timeout counter; -> WAIT.
REQ-018 WAIT SHALL increment the counter each cycle; mul_done=1 -> DONE; counter reaching TIMEOUT -> IDLE with timeout_err=1, result unchanged.
REQ-019 DONE SHALL latch result=mul_product, sign=pending sign AND (mul_product!=0), set result_valid=1, clear timeout_err; -> IDLE.
REQ-020 Load-to-result_valid latency SHALL be 3 cycles plus the multiplier's done latency.
REQ-021 busy SHALL be 1 in CAPTURE, START, WAIT, DONE; 0 in IDLE.
REQ-022 result_valid SHALL clear on the cycle after load_p is accepted and stay 0 until DONE.
REQ-023 load_p while busy SHALL be ignored (see REQ-031 for the configured alternative).
REQ-024 right_p SHALL increment win_idx saturating at 2; left_p SHALL decrement saturating at 0; both in the same cycle -> no change.
REQ-025 An accepted load_p SHALL reset win_idx to 0, taking priority over same-cycle left_p/right_p.
REQ-026 mul_done asserted outside WAIT SHALL be ignored.

Reset
REQ-027 rst=0 SHALL force immediately, independent of clk: state IDLE; mul_a, mul_b, result, counter = 0; mul_start, sign, busy, result_valid, timeout_err = 0; win_idx = 0.
REQ-028 Reset mid-operation SHALL abandon the multiplication with no result update; the first cycle after release is IDLE.

Configuration
REQ-029 Macro MULT_SEQ_PENDING_LOAD_EN SHALL control a one-deep pending-load buffer.
REQ-030 Without the macro, REQ-023 SHALL apply.
REQ-031 With the macro, load_p while busy SHALL set a pending flag, with operands captured at that cycle; on return to IDLE a set flag SHALL enter CAPTURE using the buffered operands and clear. Further loads while the flag is set SHALL overwrite the buffered operands. Reset SHALL clear the flag.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding typedef, WIDTH default, and win_idx max constant (2).
REQ-033 Sub-module abs_sign_unit SHALL be instantiated: combinational magnitude and sign-XOR of both operands.

Verification
REQ-034 num1=5, num2=-3, load_p -> mul_a=5, mul_b=3, single mul_start; model done with product 15 -> result=15, sign=1, result_valid=1.
REQ-035 num1=-128, num2=-128 -> mul_a=mul_b=128; product 16384 -> result=16384, sign=0.
REQ-036 num1=0, num2=-7 -> product 0 -> result=0, sign=0.
REQ-037 mul_done withheld for 20 cycles (TIMEOUT=20) -> return to IDLE, timeout_err=1, busy=0, previous result held.
REQ-038 Three right_p pulses then one left_p -> win_idx 1,2,2,1; right_p+left_p together -> unchanged; load_p with right_p -> 0.
REQ-039 load_p during WAIT -> ignored without the macro; with the macro, a second mul_start follows the first DONE with the buffered operands; rst=0 during WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/mult_sequencer_pkg.sv
// Shared types and constants for mult_sequencer and its sub-units.
package mult_sequencer_pkg;

  localparam int unsigned DefaultWidth = 8;
  localparam logic [1:0]  WinIdxMax    = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StCapture,
    StStart,
    StWait,
    StDone
  } state_e;

endpackage

// File: rtl/abs_sign_unit.sv
// Combinational two's-complement magnitudes of both operands and the XOR of their signs.
module abs_sign_unit #(
  parameter int unsigned WIDTH = mult_sequencer_pkg::DefaultWidth
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] mag_a,
  output logic [WIDTH-1:0] mag_b,
  output logic             neg
);

  // -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
  always_comb begin
    mag_a = a[WIDTH-1] ? -a : a;
    mag_b = b[WIDTH-1] ? -b : b;
    neg   = a[WIDTH-1] ^ b[WIDTH-1];
  end

endmodule

// File: rtl/mult_sequencer.sv
// Drives an unsigned shift-add multiplier from signed operands, with completion timeout and a
// display window index. Define MULT_SEQ_PENDING_LOAD_EN to buffer one load that arrives while busy.
module mult_sequencer
  import mult_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH   = DefaultWidth,
  parameter int unsigned TIMEOUT = 2 * WIDTH + 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_p,
  input  logic               left_p,
  input  logic               right_p,
  input  logic [WIDTH-1:0]   num1,
  input  logic [WIDTH-1:0]   num2,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  output logic               mul_start,
  input  logic               mul_done,
  input  logic [2*WIDTH-1:0] mul_product,
  output logic [2*WIDTH-1:0] result,
  output logic               sign,
  output logic               busy,
  output logic               result_valid,
  output logic               timeout_err,
  output logic [1:0]         win_idx
);

  localparam int unsigned     CntW    = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   op1_q, op1_d, op2_q, op2_d;
  logic [WIDTH-1:0]   mag1, mag2;
  logic               neg;
  logic [WIDTH-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic               sign_pend_q, sign_pend_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               sign_q, sign_d;
  logic               valid_q, valid_d;
  logic               terr_q, terr_d;
  logic [1:0]         win_q, win_d;
  logic               load_acc;
  logic               pend_q;
  logic [WIDTH-1:0]   buf1_q, buf2_q;

  abs_sign_unit #(
    .WIDTH (WIDTH)
  ) u_abs_sign (
    .a     (op1_q),
    .b     (op2_q),
    .mag_a (mag1),
    .mag_b (mag2),
    .neg   (neg)
  );

`ifdef MULT_SEQ_PENDING_LOAD_EN
  // Newest load while busy wins; the flag is consumed on the IDLE cycle it is seen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= 1'b0;
      buf1_q <= '0;
      buf2_q <= '0;
    end else if (load_p && (state_q != StIdle)) begin
      pend_q <= 1'b1;
      buf1_q <= num1;
      buf2_q <= num2;
    end else if (state_q == StIdle) begin
      pend_q <= 1'b0;
    end
  end
`else
  assign pend_q = 1'b0;
  assign buf1_q = '0;
  assign buf2_q = '0;
`endif

  always_comb begin
    state_d     = state_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    sign_pend_d = sign_pend_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    sign_d      = sign_q;
    valid_d     = valid_q;
    terr_d      = terr_q;
    win_d       = win_q;
    mul_start   = 1'b0;
    load_acc    = load_p && (state_q == StIdle);

    unique case (state_q)
      StIdle: begin
        if (load_p) begin
          op1_d   = num1;
          op2_d   = num2;
          valid_d = 1'b0;
          state_d = StCapture;
        end else if (pend_q) begin
          op1_d   = buf1_q;
          op2_d   = buf2_q;
          valid_d = 1'b0;
          state_d = StCapture;
        end
      end
      StCapture: begin
        mul_a_d     = mag1;
        mul_b_d     = mag2;
        sign_pend_d = neg;
        state_d     = StStart;
      end
      StStart: begin
        mul_start = 1'b1;
        cnt_d     = '0;
        state_d   = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        // Product is taken together with mul_done, so a non-holding multiplier also works.
        if (mul_done) begin
          result_d = mul_product;
          sign_d   = sign_pend_q && (mul_product != '0);
          valid_d  = 1'b1;
          terr_d   = 1'b0;
          state_d  = StDone;
        end else if (cnt_q == CntLast) begin
          terr_d  = 1'b1;
          state_d = StIdle;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (load_acc) begin
      win_d = '0;
    end else if (right_p && !left_p && (win_q != WinIdxMax)) begin
      win_d = win_q + 2'd1;
    end else if (left_p && !right_p && (win_q != 2'd0)) begin
      win_d = win_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      op1_q       <= '0;
      op2_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      sign_pend_q <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      sign_q      <= 1'b0;
      valid_q     <= 1'b0;
      terr_q      <= 1'b0;
      win_q       <= '0;
    end else begin
      state_q     <= state_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      sign_pend_q <= sign_pend_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      sign_q      <= sign_d;
      valid_q     <= valid_d;
      terr_q      <= terr_d;
      win_q       <= win_d;
    end
  end

  assign mul_a        = mul_a_q;
  assign mul_b        = mul_b_q;
  assign result       = result_q;
  assign sign         = sign_q;
  assign busy         = (state_q != StIdle);
  assign result_valid = valid_q;
  assign timeout_err  = terr_q;
  assign win_idx      = win_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer with a behavioural multiplier and a result scoreboard.
module tb_mult_sequencer;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned TIMEOUT = 20;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             load_p = 1'b0, left_p = 1'b0, right_p = 1'b0;
  logic [WIDTH-1:0] num1 = '0, num2 = '0;
  logic [WIDTH-1:0] mul_a, mul_b;
  logic             mul_start;
  logic             mul_done = 1'b0;
  logic [15:0]      mul_product = '0;
  logic [15:0]      result;
  logic             sign, busy, result_valid, timeout_err;
  logic [1:0]       win_idx;

  mult_sequencer #(
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load_p       (load_p),
    .left_p       (left_p),
    .right_p      (right_p),
    .num1         (num1),
    .num2         (num2),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_start    (mul_start),
    .mul_done     (mul_done),
    .mul_product  (mul_product),
    .result       (result),
    .sign         (sign),
    .busy         (busy),
    .result_valid (result_valid),
    .timeout_err  (timeout_err),
    .win_idx      (win_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    logic        s;
  } exp_t;
  exp_t sb[$];

  // Behavioural multiplier: done pulse mul_lat negedges after the start strobe is seen.
  int          mul_lat   = 0;
  bit          mul_hold  = 1'b0;
  bit          stray     = 1'b0;
  int          mul_cnt   = -1;
  int          start_cnt = 0;
  logic [15:0] mul_res   = '0;

  always @(negedge clk) begin
    mul_done = 1'b0;
    if (mul_cnt == 0) begin
      mul_done    = 1'b1;
      mul_product = mul_res;
      mul_cnt     = -1;
    end else if (mul_cnt > 0) begin
      mul_cnt--;
    end
    if (mul_start) begin
      start_cnt++;
      mul_res = 16'(mul_a) * 16'(mul_b);
      mul_cnt = mul_hold ? -1 : mul_lat;
    end
    if (stray) begin
      mul_done    = 1'b1;
      mul_product = 16'hBEEF;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mag(input logic [7:0] v);
    int x;
    x = int'($signed(v));
    if (x < 0) x = -x;
    return x[7:0];
  endfunction

  task automatic push_exp(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.a = mag(a);
    e.b = mag(b);
    e.p = 16'(e.a) * 16'(e.b);
    e.s = (a[7] ^ b[7]) && (e.p != 16'd0);
    sb.push_back(e);
  endtask

  // Drives a load at the current negedge and checks CAPTURE and START; ends at START.
  task automatic do_load(input logic [7:0] a, input logic [7:0] b, input bit with_right);
    logic [7:0] ea, eb;
    ea = mag(a);
    eb = mag(b);
    num1 = a; num2 = b; load_p = 1'b1; right_p = with_right;
    cyc = 0;
    @(negedge clk); cyc++;
    load_p = 1'b0; right_p = 1'b0; num1 = 8'h55; num2 = 8'hAA;
    check("busy_capture", busy, 1);
    check("valid_cleared", result_valid, 0);
    if (with_right) check("win_load_prio", win_idx, 0);
    @(negedge clk); cyc++;
    check("mul_start", mul_start, 1);
    check("mul_a", mul_a, ea);
    check("mul_b", mul_b, eb);
  endtask

  task automatic wait_result(input string tag, input bit chk_lat, input int s0, input int nstart);
    exp_t e;
    while (!result_valid && cyc < 100) begin
      @(negedge clk); cyc++;
    end
    check({tag, "_valid"}, result_valid, 1);
    if (chk_lat) check({tag, "_latency"}, cyc, 4 + mul_lat);
    check({tag, "_sb_nonempty"}, (sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_result"}, result, e.p);
      check({tag, "_sign"}, sign, e.s);
    end
    check({tag, "_starts"}, start_cnt - s0, nstart);
  endtask

  task automatic pulse(input bit r, input bit l, input logic [1:0] exp_win, input string tag);
    right_p = r; left_p = l;
    @(negedge clk);
    right_p = 1'b0; left_p = 1'b0;
    check(tag, win_idx, exp_win);
  endtask

  initial begin
    int s0;
    // Reset state
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", result_valid, 0);
    check("rst_result", result, 0);
    check("rst_start", mul_start, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_win", win_idx, 0);
    check("rst_mul_a", mul_a, 0);
    rst = 1'b1;
    @(negedge clk);

    // 5 * -3
    mul_lat = 2; s0 = start_cnt;
    push_exp(8'd5, 8'hFD); do_load(8'd5, 8'hFD, 1'b0);
    wait_result("p5m3", 1'b1, s0, 1);
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_valid_held", result_valid, 1);

    // -128 * -128: magnitude 128 unsaturated
    mul_lat = 3; s0 = start_cnt;
    push_exp(8'h80, 8'h80); do_load(8'h80, 8'h80, 1'b0);
    wait_result("m128sq", 1'b1, s0, 1);
    @(negedge clk);

    // 0 * -7: zero product is never negative
    mul_lat = 0; s0 = start_cnt;
    push_exp(8'd0, 8'hF9); do_load(8'd0, 8'hF9, 1'b0);
    wait_result("zero", 1'b1, s0, 1);
    @(negedge clk);

    // Stray mul_done while idle
    stray = 1'b1;
    repeat (2) @(negedge clk);
    stray = 1'b0;
    @(negedge clk);
    check("stray_result", result, 0);
    check("stray_valid", result_valid, 1);
    check("stray_busy", busy, 0);

    // Window index
    pulse(1'b1, 1'b0, 2'd1, "win_r1");
    pulse(1'b1, 1'b0, 2'd2, "win_r2");
    pulse(1'b1, 1'b0, 2'd2, "win_r3_sat");
    pulse(1'b0, 1'b1, 2'd1, "win_l1");
    pulse(1'b1, 1'b1, 2'd1, "win_both");
    pulse(1'b0, 1'b1, 2'd0, "win_l2");
    pulse(1'b0, 1'b1, 2'd0, "win_l_sat");
    pulse(1'b1, 1'b0, 2'd1, "win_r4");
    mul_lat = 1; s0 = start_cnt;
    push_exp(8'hFC, 8'd5); do_load(8'hFC, 8'd5, 1'b1);
    wait_result("m4p5", 1'b1, s0, 1);
    @(negedge clk);

    // Timeout: result 20 negative must be held
    mul_hold = 1'b1;
    do_load(8'd7, 8'd9, 1'b0);
    while (busy && cyc < 100) begin
      @(negedge clk); cyc++;
    end
    check("to_cycles", cyc, 3 + TIMEOUT);
    check("to_busy", busy, 0);
    check("to_err", timeout_err, 1);
    check("to_result_held", result, 16'd20);
    check("to_sign_held", sign, 1);
    check("to_valid", result_valid, 0);
    mul_hold = 1'b0;
    @(negedge clk);

    // Load during WAIT
    mul_lat = 5; s0 = start_cnt;
    push_exp(8'd3, 8'd4); do_load(8'd3, 8'd4, 1'b0);
    @(negedge clk); cyc++;
    num1 = 8'd2; num2 = 8'hFE; load_p = 1'b1;
`ifdef MULT_SEQ_PENDING_LOAD_EN
    push_exp(8'd2, 8'hFE);
`endif
    @(negedge clk); cyc++;
    load_p = 1'b0;
    wait_result("ldwait1", 1'b1, s0, 1);
    check("ldwait_terr_clr", timeout_err, 0);
    repeat (2) @(negedge clk);
`ifdef MULT_SEQ_PENDING_LOAD_EN
    cyc = 0;
    wait_result("ldwait2", 1'b0, s0, 2);
    @(negedge clk);
`else
    repeat (8) @(negedge clk);
    check("ldwait_ignored_busy", busy, 0);
    check("ldwait_ignored_starts", start_cnt - s0, 1);
`endif

    // Asynchronous reset during WAIT
    mul_hold = 1'b1;
    do_load(8'd6, 8'd6, 1'b0);
    @(negedge clk);
    right_p = 1'b1;
    @(negedge clk);
    right_p = 1'b0;
    check("pre_rst_win", win_idx, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_start", mul_start, 0);
    check("arst_mul_a", mul_a, 0);
    check("arst_mul_b", mul_b, 0);
    check("arst_result", result, 0);
    check("arst_sign", sign, 0);
    check("arst_valid", result_valid, 0);
    check("arst_terr", timeout_err, 0);
    check("arst_win", win_idx, 0);
    @(negedge clk);
    rst = 1'b1;
    mul_hold = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_valid", result_valid, 0);
    check("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
